// File: rtl/bias_relu_sat_layer11_pkg.sv
// bias_relu_sat_layer11_pkg: shared widths, saturation limits and lane slicing for the layer 11 post-accumulation stage
package bias_relu_sat_layer11_pkg;
  localparam int DATA_W = 18;
  localparam int N_ADDER_TREE = 16;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  function automatic logic [DATA_W-1:0] lane_slice(input logic [N_ADDER_TREE*DATA_W-1:0] v, input int i);
    return v[i*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/bias_relu_lane.sv
// bias_relu_lane: per-lane bias add (S1 input) and ReLU + saturate (S2 input), combinational only
module bias_relu_lane
  import bias_relu_sat_layer11_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic [DATA_W-1:0] in_val,
  input  logic [DATA_W-1:0] bias_val,
  output logic [DATA_W:0]   sum,
  input  logic [DATA_W:0]   acc,
  output logic [DATA_W-1:0] res,
  output logic              sat
);
  logic [DATA_W:0] act;
  logic hi, lo;
  always_comb begin
    sum = {in_val[DATA_W-1], in_val} + {bias_val[DATA_W-1], bias_val};
    act = (RELU_EN && acc[DATA_W]) ? '0 : acc;
    // the two top bits of the widened sum disagree exactly when it leaves the DATA_W range
    hi = !act[DATA_W] & act[DATA_W-1];
    lo = act[DATA_W] & !act[DATA_W-1];
    sat = hi | lo;
    res = hi ? SAT_MAX : lo ? SAT_MIN : act[DATA_W-1:0];
  end
endmodule

// File: rtl/bias_relu_sat_layer11.sv
// bias_relu_sat_layer11: 2-stage bias/ReLU/saturate pipeline with valid/ready and tile-last beat counter
module bias_relu_sat_layer11
  import bias_relu_sat_layer11_pkg::*;
#(
  parameter bit RELU_EN = 1'b1,
  parameter int BEATS_PER_TILE = 34
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_ADDER_TREE*DATA_W-1:0] bias,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_ADDER_TREE*DATA_W-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_ADDER_TREE*DATA_W-1:0] out_data,
  output logic [N_ADDER_TREE-1:0]        out_sat,
  output logic                           out_last
);
  localparam int CW = BEATS_PER_TILE > 1 ? $clog2(BEATS_PER_TILE) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS_PER_TILE - 1);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_load, s2_load;
  logic [N_ADDER_TREE-1:0][DATA_W:0] s1_sum_q, s1_sum_d, sum;
  logic [N_ADDER_TREE*DATA_W-1:0] out_data_q, out_data_d, res;
  logic [N_ADDER_TREE-1:0] out_sat_q, out_sat_d, sat;
  logic [CW-1:0] count_q, count_d;
  for (genvar l = 0; l < N_ADDER_TREE; l++) begin : g_lane
    bias_relu_lane #(.RELU_EN(RELU_EN)) u_lane (
      .in_val  (lane_slice(in_data, l)),
      .bias_val(lane_slice(bias, l)),
      .sum     (sum[l]),
      .acc     (s1_sum_q[l]),
      .res     (res[l*DATA_W +: DATA_W]),
      .sat     (sat[l])
    );
  end
  always_comb begin
    s2_load = !s2_valid_q | out_ready;
    s1_load = !s1_valid_q | s2_load;
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s1_sum_d = (s1_load & in_valid) ? sum : s1_sum_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    out_data_d = (s2_load & s1_valid_q) ? res : out_data_q;
    out_sat_d = (s2_load & s1_valid_q) ? sat : out_sat_q;
    count_d = !(s2_valid_q & out_ready) ? count_q : (count_q == LAST) ? '0 : count_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sum_q <= '0;
      out_data_q <= '0;
      out_sat_q <= '0;
      count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_sum_q <= s1_sum_d;
      out_data_q <= out_data_d;
      out_sat_q <= out_sat_d;
      count_q <= count_d;
    end
  end
  assign in_ready = s1_load;
  assign out_valid = s2_valid_q;
  assign out_data = out_data_q;
  assign out_sat = out_sat_q;
  assign out_last = s2_valid_q & (count_q == LAST);
endmodule

// File: tb/tb_bias_relu_sat_layer11.sv
// tb_bias_relu_sat_layer11: directed vector table plus streaming/stall/reset sequences against an integer reference model
module tb_bias_relu_sat_layer11;
  localparam int W = 18;
  localparam int N = 16;
  localparam int VW = N * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [VW-1:0] bias = '0, in_data = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last, in_ready0, out_valid0, out_last0;
  logic [VW-1:0] out_data, out_data0;
  logic [N-1:0] out_sat, out_sat0;

  always #5 clk = ~clk;

  bias_relu_sat_layer11 #(.RELU_EN(1'b1), .BEATS_PER_TILE(34)) dut (
    .clk(clk), .rst(rst), .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .out_last(out_last)
  );
  bias_relu_sat_layer11 #(.RELU_EN(1'b0), .BEATS_PER_TILE(34)) dut0 (
    .clk(clk), .rst(rst), .bias(bias), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0), .out_last(out_last0)
  );

  typedef struct {
    int lane;
    logic [W-1:0] a, b, e1, e0;
    logic s1, s0;
  } vec_t;
  typedef struct {
    logic [VW-1:0] d1, d0;
    logic [N-1:0] s1, s0;
  } exp_t;

  vec_t tbl[7];
  exp_t exp_q[$];
  int last_at[$];
  int n_chk = 0, n_fail = 0, exp_cnt = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model(input logic [VW-1:0] din, input logic [VW-1:0] b, input bit relu,
                       output logic [VW-1:0] d, output logic [N-1:0] s);
    int x;
    for (int i = 0; i < N; i++) begin
      x = int'($signed(din[i*W +: W])) + int'($signed(b[i*W +: W]));
      if (relu && x < 0) x = 0;
      s[i] = 1'b0;
      if (x > 131071) begin d[i*W +: W] = 18'h1FFFF; s[i] = 1'b1; end
      else if (x < -131072) begin d[i*W +: W] = 18'h20000; s[i] = 1'b1; end
      else d[i*W +: W] = x[W-1:0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic run_single(input vec_t t);
    logic [VW-1:0] iv, bv, e1, e0;
    logic [N-1:0] s1, s0;
    iv = '0; bv = '0; e1 = '0; e0 = '0; s1 = '0; s0 = '0;
    iv[t.lane*W +: W] = t.a; bv[t.lane*W +: W] = t.b;
    e1[t.lane*W +: W] = t.e1; e0[t.lane*W +: W] = t.e0;
    s1[t.lane] = t.s1; s0[t.lane] = t.s0;
    @(negedge clk);
    in_data = iv; bias = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("single_lat1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data_relu", out_data, e1);
    chk("single_sat_relu", out_sat, s1);
    chk("single_valid_norelu", out_valid0, 1'b1);
    chk("single_data_norelu", out_data0, e0);
    chk("single_sat_norelu", out_sat0, s0);
    chk("single_last", out_last, exp_cnt == 33);
    exp_cnt = (exp_cnt == 33) ? 0 : exp_cnt + 1;
  endtask

  task automatic run_stream(input int n, input int pct, input bit full_rate);
    int sent, got, cyc;
    logic [VW-1:0] cur;
    exp_t e;
    sent = 0; got = 0; cyc = 0;
    cur = rnd_vec();
    last_at.delete();
    while (got < n && cyc < n * 20 + 50) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(99) < pct);
      in_valid = (sent < n);
      in_data = cur;
      #1;
      chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data_relu", out_data, e.d1);
          chk("stream_sat_relu", out_sat, e.s1);
          chk("stream_data_norelu", out_data0, e.d0);
          chk("stream_sat_norelu", out_sat0, e.s0);
        end
        chk("stream_last", out_last, exp_cnt == 33);
        if (out_last) last_at.push_back(got);
        got++;
        exp_cnt = (exp_cnt == 33) ? 0 : exp_cnt + 1;
      end
      if (in_valid && in_ready) begin
        model(cur, bias, 1'b1, e.d1, e.s1);
        model(cur, bias, 1'b0, e.d0, e.s0);
        exp_q.push_back(e);
        sent++;
        cur = rnd_vec();
      end
    end
    in_valid = 1'b0;
    chk("stream_beats_out", got, n);
    if (full_rate) chk("stream_cycles", cyc, n + 2);
  endtask

  initial begin
    tbl[0] = '{0,  18'h00100, 18'h00AE0, 18'h00BE0, 18'h00BE0, 1'b0, 1'b0};
    tbl[1] = '{3,  18'h1FFFF, 18'h00001, 18'h1FFFF, 18'h1FFFF, 1'b1, 1'b1};
    tbl[2] = '{5,  18'h20000, 18'h3FFFF, 18'h00000, 18'h20000, 1'b0, 1'b1};
    tbl[3] = '{7,  18'h3FFFF, 18'h00000, 18'h00000, 18'h3FFFF, 1'b0, 1'b0};
    tbl[4] = '{15, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 1'b1, 1'b1};
    tbl[5] = '{9,  18'h20000, 18'h20000, 18'h00000, 18'h20000, 1'b0, 1'b1};
    tbl[6] = '{12, 18'h00005, 18'h3FFFB, 18'h00000, 18'h00000, 1'b0, 1'b0};

    do_reset();
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_sat", out_sat, '0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_single(tbl[i]);

    do_reset();
    bias = rnd_vec();
    run_stream(68, 100, 1'b1);
    chk("last_count", last_at.size(), 2);
    if (last_at.size() == 2) begin
      chk("last_beat_a", last_at[0], 33);
      chk("last_beat_b", last_at[1], 67);
    end

    bias = rnd_vec();
    run_stream(200, 50, 1'b0);

    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = rnd_vec();
    @(negedge clk);
    in_data = rnd_vec();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_cnt = 0;
    exp_q.delete();
    #1;
    chk("rst_full_out_valid", out_valid, 1'b0);
    chk("rst_full_out_data", out_data, '0);
    chk("rst_full_out_sat", out_sat, '0);
    chk("rst_full_out_last", out_last, 1'b0);
    chk("rst_full_in_ready", in_ready, 1'b1);
    run_stream(34, 100, 1'b1);
    chk("rst_last_count", last_at.size(), 1);
    if (last_at.size() == 1) chk("rst_last_beat", last_at[0], 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
